// File: rtl/memctrl_arb_if.sv
// Core-side (fetch/data) and bus-side signals of memctrl_arb.
// master = controller view, slave = core/bus environment view.
interface memctrl_arb_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [BE_W-1:0]   bus_be;
  logic              bus_read;
  logic              bus_write;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_busy;
  logic [1:0]        state;
  logic              err;

  modport master (
    input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_be, bus_rdata, bus_busy,
    output i_rdata, i_ack, d_rdata, d_ack, bus_addr, bus_wdata, bus_be, bus_read, bus_write,
           state, err
  );

  modport slave (
    output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_be, bus_rdata, bus_busy,
    input  i_rdata, i_ack, d_rdata, d_ack, bus_addr, bus_wdata, bus_be, bus_read, bus_write,
           state, err
  );
endinterface

// File: rtl/memctrl_arb.sv
// Two-port (fetch/data) memory controller arbitrating onto one bus master.
// Optional WAIT timeout abort enabled by defining MEMCTRL_TIMEOUT_EN.
module memctrl_arb #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned FIX_PRIORITY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic           clk,
  input logic           rst,
  memctrl_arb_if.master mem_if
);
  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BE_W - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StDone = 2'd3
  } state_e;

  state_e            r_state, w_state;
  logic              r_grant_d, w_grant_d;
  logic              r_last_d, w_last_d;
  logic              r_write, w_write;
  logic [ADDR_W-1:0] r_bus_addr, w_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata;
  logic [BE_W-1:0]   r_bus_be, w_bus_be;
  logic              r_bus_read, w_bus_read;
  logic              r_bus_write, w_bus_write;
  logic [DATA_W-1:0] r_i_rdata, w_i_rdata;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata;
  logic              r_i_ack, w_i_ack;
  logic              r_d_ack, w_d_ack;
  logic              r_err, w_err;
  logic              w_d_req, w_pick_d;

`ifdef MEMCTRL_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 255) ? 16 : 8;
  logic [CNT_W-1:0] r_cnt, w_cnt;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

  // A simultaneous read+write request is treated as a write.
  assign w_d_req = mem_if.d_read | mem_if.d_write;

  always_comb begin
    w_pick_d = w_d_req;
    if (w_d_req && mem_if.i_req) begin
      w_pick_d = (FIX_PRIORITY != 0) ? 1'b1 : ~r_last_d;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_grant_d   = r_grant_d;
    w_last_d    = r_last_d;
    w_write     = r_write;
    w_bus_addr  = r_bus_addr;
    w_bus_wdata = r_bus_wdata;
    w_bus_be    = r_bus_be;
    w_bus_read  = 1'b0;
    w_bus_write = 1'b0;
    w_i_rdata   = r_i_rdata;
    w_d_rdata   = r_d_rdata;
    w_i_ack     = 1'b0;
    w_d_ack     = 1'b0;
    w_err       = r_err;
`ifdef MEMCTRL_TIMEOUT_EN
    w_cnt       = r_cnt;
`endif
    unique case (r_state)
      StIdle: begin
        w_err = 1'b0;
        if (mem_if.i_req || w_d_req) begin
          w_state   = StReq;
          w_grant_d = w_pick_d;
          w_last_d  = w_pick_d;
          if (w_pick_d) begin
            w_write     = mem_if.d_write;
            w_bus_addr  = mem_if.d_addr & ADDR_MASK;
            w_bus_wdata = mem_if.d_write ? mem_if.d_wdata : '0;
            w_bus_be    = mem_if.d_write ? mem_if.d_be : '1;
            w_bus_read  = ~mem_if.d_write;
            w_bus_write = mem_if.d_write;
          end else begin
            w_write     = 1'b0;
            w_bus_addr  = mem_if.i_addr & ADDR_MASK;
            w_bus_wdata = '0;
            w_bus_be    = '1;
            w_bus_read  = 1'b1;
          end
        end
      end
      StReq: begin
        w_state = StWait;
`ifdef MEMCTRL_TIMEOUT_EN
        w_cnt   = '0;
`endif
      end
      StWait: begin
        if (!mem_if.bus_busy) begin
          w_state = StDone;
          if (r_grant_d) begin
            w_d_ack = 1'b1;
            if (!r_write) w_d_rdata = mem_if.bus_rdata;
          end else begin
            w_i_ack   = 1'b1;
            w_i_rdata = mem_if.bus_rdata;
          end
        end
`ifdef MEMCTRL_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state = StDone;
          w_err   = 1'b1;
          if (r_grant_d) begin
            w_d_ack   = 1'b1;
            w_d_rdata = '0;
          end else begin
            w_i_ack   = 1'b1;
            w_i_rdata = '0;
          end
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
`endif
      end
      StDone: begin
        w_state = StIdle;
        w_err   = 1'b0;
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_grant_d   <= 1'b0;
      r_last_d    <= 1'b0;
      r_write     <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_bus_read  <= 1'b0;
      r_bus_write <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_err       <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
      r_cnt       <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_grant_d   <= w_grant_d;
      r_last_d    <= w_last_d;
      r_write     <= w_write;
      r_bus_addr  <= w_bus_addr;
      r_bus_wdata <= w_bus_wdata;
      r_bus_be    <= w_bus_be;
      r_bus_read  <= w_bus_read;
      r_bus_write <= w_bus_write;
      r_i_rdata   <= w_i_rdata;
      r_d_rdata   <= w_d_rdata;
      r_i_ack     <= w_i_ack;
      r_d_ack     <= w_d_ack;
      r_err       <= w_err;
`ifdef MEMCTRL_TIMEOUT_EN
      r_cnt       <= w_cnt;
`endif
    end
  end

  assign mem_if.bus_addr  = r_bus_addr;
  assign mem_if.bus_wdata = r_bus_wdata;
  assign mem_if.bus_be    = r_bus_be;
  assign mem_if.bus_read  = r_bus_read;
  assign mem_if.bus_write = r_bus_write;
  assign mem_if.i_rdata   = r_i_rdata;
  assign mem_if.d_rdata   = r_d_rdata;
  assign mem_if.i_ack     = r_i_ack;
  assign mem_if.d_ack     = r_d_ack;
  assign mem_if.err       = r_err;
  assign mem_if.state     = r_state;
endmodule

// File: tb/tb_memctrl_arb.sv
// Scoreboard bench for memctrl_arb: reset, read, sub-word write, arbitration,
// reset mid-access and WAIT timeout (MEMCTRL_TIMEOUT_EN) behaviour.
module tb_memctrl_arb;
  localparam logic [31:0] SALT = 32'h5A5A_0000;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [31:0] exp_i_rdata, exp_d_rdata;
  bit          use_fn = 1'b0;
  logic [31:0] fix_rdata = 32'h0;

  memctrl_arb_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  memctrl_arb #(
    .ADDR_W(32), .DATA_W(32), .FIX_PRIORITY(0), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_if(mif)
  );

  always #5 clk = ~clk;

  // Bus slave: returns either a fixed word or the address xor a salt.
  always_comb mif.bus_rdata = use_fn ? (mif.bus_addr ^ SALT) : fix_rdata;

  // Waits for an ack, driving bus_busy high for the first busy_cyc WAIT cycles.
  task automatic wait_ack(input int max_cyc, input int busy_cyc, input bit drop,
                          output bit ok, output int n_cyc, output int n_wait,
                          output int n_rd, output int n_wr, output logic [31:0] s_addr,
                          output logic [3:0] s_be, output logic [31:0] s_wdata);
    ok = 0; n_cyc = 0; n_wait = 0; n_rd = 0; n_wr = 0;
    s_addr = '0; s_be = '0; s_wdata = '0;
    while (!ok && n_cyc < max_cyc) begin
      @(negedge clk);
      n_cyc++;
      if (mif.bus_read) n_rd++;
      if (mif.bus_write) n_wr++;
      if (mif.bus_read || mif.bus_write) begin
        s_addr = mif.bus_addr; s_be = mif.bus_be; s_wdata = mif.bus_wdata;
      end
      if (mif.state == 2'd2) begin
        n_wait++;
        mif.bus_busy = (n_wait <= busy_cyc);
      end
      if (mif.i_ack || mif.d_ack) begin
        ok = 1;
        if (drop && mif.i_ack) mif.i_req = 1'b0;
        if (drop && mif.d_ack) begin mif.d_read = 1'b0; mif.d_write = 1'b0; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mif.i_req = 1'b1; mif.i_addr = 32'h80; mif.d_read = 1'b0; mif.d_write = 1'b1;
    mif.d_addr = 32'h10; mif.d_wdata = 32'h55; mif.d_be = 4'hF; mif.bus_busy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (mif.state !== 2'd0) begin
        errors++; $display("FAIL reset_state c%0d: got %0d want 0", c, mif.state);
      end
      checks++;
      if ({mif.bus_read, mif.bus_write, mif.i_ack, mif.d_ack, mif.err} !== 5'b0) begin
        errors++;
        $display("FAIL reset_strobes c%0d: rd/wr/iack/dack/err got %b want 00000", c,
                 {mif.bus_read, mif.bus_write, mif.i_ack, mif.d_ack, mif.err});
      end
      checks++;
      if ({mif.bus_addr, mif.bus_wdata, mif.i_rdata, mif.d_rdata, mif.bus_be} !== '0) begin
        errors++; $display("FAIL reset_regs c%0d: addr %h rdata %h/%h want 0", c,
                           mif.bus_addr, mif.i_rdata, mif.d_rdata);
      end
    end
    rst = 1'b0; mif.i_req = 1'b0; mif.d_write = 1'b0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    @(negedge clk);
    checks++;
    if (mif.state !== 2'd0 || mif.bus_read !== 1'b0 || mif.bus_write !== 1'b0) begin
      errors++; $display("FAIL reset_release: state %0d rd %b wr %b want 0 0 0",
                         mif.state, mif.bus_read, mif.bus_write);
    end
  endtask

  task automatic test_read();
    bit ok; int n_cyc, n_wait, n_rd, n_wr; logic [31:0] a, w; logic [3:0] be; exp_t e;
    @(negedge clk);
    use_fn = 1'b0; fix_rdata = 32'hDEAD_BEEF; mif.bus_busy = 1'b0;
    mif.d_addr = 32'h0000_1007; mif.d_read = 1'b1;
    sb.push_back('{is_d: 1'b1, rdata: 32'hDEAD_BEEF});
    wait_ack(20, 0, 1, ok, n_cyc, n_wait, n_rd, n_wr, a, be, w);
    e = sb.pop_front();
    exp_d_rdata = e.rdata;
    checks++;
    if (!ok || n_cyc != 3) begin
      errors++; $display("FAIL read_latency: ack %0d after %0d cycles want 1 after 3", ok, n_cyc);
    end
    checks++;
    if (a !== 32'h0000_1004 || be !== 4'hF) begin
      errors++; $display("FAIL read_bus: addr %h be %h want 00001004 f", a, be);
    end
    checks++;
    if (n_rd != 1 || n_wr != 0) begin
      errors++; $display("FAIL read_strobe: rd %0d wr %0d want 1 0", n_rd, n_wr);
    end
    checks++;
    if (mif.d_ack !== 1'b1 || mif.i_ack !== 1'b0 || mif.d_rdata !== exp_d_rdata) begin
      errors++; $display("FAIL read_ack: dack %b iack %b rdata %h want 1 0 %h",
                         mif.d_ack, mif.i_ack, mif.d_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_write();
    bit ok; int n_cyc, n_wait, n_rd, n_wr; logic [31:0] a, w; logic [3:0] be; exp_t e;
    @(negedge clk);
    fix_rdata = 32'h1111_1111; mif.bus_busy = 1'b1;
    mif.d_addr = 32'h0000_2000; mif.d_wdata = 32'h0000_00AB; mif.d_be = 4'b0001;
    mif.d_write = 1'b1;
    sb.push_back('{is_d: 1'b1, rdata: exp_d_rdata});
    wait_ack(30, 4, 1, ok, n_cyc, n_wait, n_rd, n_wr, a, be, w);
    e = sb.pop_front();
    checks++;
    if (!ok || n_wait != 5) begin
      errors++; $display("FAIL write_wait: ack %0d wait_cycles %0d want 1 5", ok, n_wait);
    end
    checks++;
    if (n_wr != 1 || n_rd != 0 || be !== 4'b0001 || w !== 32'hAB) begin
      errors++; $display("FAIL write_bus: wr %0d rd %0d be %b wdata %h want 1 0 0001 000000ab",
                         n_wr, n_rd, be, w);
    end
    checks++;
    if (mif.d_ack !== 1'b1 || mif.d_rdata !== e.rdata) begin
      errors++; $display("FAIL write_ack: dack %b rdata %h want 1 %h", mif.d_ack, mif.d_rdata,
                         e.rdata);
    end
    // Read and write together must become a write.
    @(negedge clk);
    mif.bus_busy = 1'b0;
    mif.d_addr = 32'h0000_2002; mif.d_wdata = 32'h1234_5678; mif.d_be = 4'b1100;
    mif.d_read = 1'b1; mif.d_write = 1'b1;
    sb.push_back('{is_d: 1'b1, rdata: exp_d_rdata});
    wait_ack(20, 0, 1, ok, n_cyc, n_wait, n_rd, n_wr, a, be, w);
    e = sb.pop_front();
    checks++;
    if (!ok || n_wr != 1 || n_rd != 0 || a !== 32'h2000 || be !== 4'b1100) begin
      errors++; $display("FAIL rw_both: ack %0d wr %0d rd %0d addr %h be %b want 1 1 0 2000 1100",
                         ok, n_wr, n_rd, a, be);
    end
    checks++;
    if (mif.d_rdata !== e.rdata) begin
      errors++; $display("FAIL rw_both_rdata: got %h want %h", mif.d_rdata, e.rdata);
    end
  endtask

  task automatic test_arbitration();
    bit ok; int n_cyc, n_wait, n_rd, n_wr, tot, extra; logic [31:0] a, w; logic [3:0] be;
    exp_t e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    use_fn = 1'b1; mif.bus_busy = 1'b0;
    mif.i_addr = 32'h100; mif.d_addr = 32'h204; mif.i_req = 1'b1; mif.d_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      sb.push_back('{is_d: (k % 2 == 0), rdata: ((k % 2 == 0) ? 32'h204 : 32'h100) ^ SALT});
    end
    tot = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ack(20, 0, 0, ok, n_cyc, n_wait, n_rd, n_wr, a, be, w);
      tot += n_rd;
      e = sb.pop_front();
      if (e.is_d) exp_d_rdata = e.rdata;
      else exp_i_rdata = e.rdata;
      checks++;
      if (!ok || {mif.i_ack, mif.d_ack} !== {!e.is_d, e.is_d}) begin
        errors++; $display("FAIL arb_grant #%0d: iack/dack %b%b want %b%b", k, mif.i_ack,
                           mif.d_ack, !e.is_d, e.is_d);
      end
      checks++;
      if (mif.i_rdata !== exp_i_rdata || mif.d_rdata !== exp_d_rdata) begin
        errors++; $display("FAIL arb_rdata #%0d: i %h d %h want %h %h", k, mif.i_rdata,
                           mif.d_rdata, exp_i_rdata, exp_d_rdata);
      end
    end
    mif.i_req = 1'b0; mif.d_read = 1'b0;
    extra = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mif.bus_read || mif.bus_write || mif.i_ack || mif.d_ack) extra++;
    end
    checks++;
    if (tot != 4 || extra != 0) begin
      errors++; $display("FAIL arb_issue_count: strobes %0d extra %0d want 4 0", tot, extra);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok; int n_cyc, n_wait, n_rd, n_wr, c; logic [31:0] a, w; logic [3:0] be; exp_t e;
    mif.bus_busy = 1'b1; mif.i_addr = 32'h40; mif.i_req = 1'b1;
    c = 0;
    do begin
      @(negedge clk); c++;
    end while (mif.state != 2'd2 && c < 10);
    checks++;
    if (mif.state !== 2'd2) begin
      errors++; $display("FAIL rstwait_reach: state %0d want 2", mif.state);
    end
    rst = 1'b1; mif.i_req = 1'b0;
    @(negedge clk);
    rst = 1'b0; exp_i_rdata = '0; exp_d_rdata = '0;
    checks++;
    if (mif.state !== 2'd0 || mif.i_ack !== 1'b0 || mif.d_ack !== 1'b0 ||
        mif.bus_read !== 1'b0) begin
      errors++; $display("FAIL rstwait_abort: state %0d iack %b dack %b rd %b want 0 0 0 0",
                         mif.state, mif.i_ack, mif.d_ack, mif.bus_read);
    end
    mif.bus_busy = 1'b0; use_fn = 1'b1; mif.i_req = 1'b1;
    sb.push_back('{is_d: 1'b0, rdata: 32'h40 ^ SALT});
    wait_ack(20, 0, 1, ok, n_cyc, n_wait, n_rd, n_wr, a, be, w);
    e = sb.pop_front();
    exp_i_rdata = e.rdata;
    checks++;
    if (!ok || n_cyc != 3 || a !== 32'h40 || mif.i_ack !== 1'b1) begin
      errors++; $display("FAIL rstwait_reissue: ack %0d cyc %0d addr %h want 1 3 00000040",
                         ok, n_cyc, a);
    end
    checks++;
    if (mif.i_rdata !== exp_i_rdata || mif.d_rdata !== exp_d_rdata) begin
      errors++; $display("FAIL rstwait_rdata: i %h d %h want %h %h", mif.i_rdata, mif.d_rdata,
                         exp_i_rdata, exp_d_rdata);
    end
  endtask

  task automatic test_timeout();
    bit ok; int n_cyc, n_wait, n_rd, n_wr; logic [31:0] a, w; logic [3:0] be;
    @(negedge clk);
    use_fn = 1'b1; mif.bus_busy = 1'b1; mif.d_addr = 32'h300; mif.d_read = 1'b1;
`ifdef MEMCTRL_TIMEOUT_EN
    exp_d_rdata = '0;
    wait_ack(40, 1000, 1, ok, n_cyc, n_wait, n_rd, n_wr, a, be, w);
    checks++;
    if (!ok || n_wait != 8) begin
      errors++; $display("FAIL timeout_len: ack %0d wait_cycles %0d want 1 8", ok, n_wait);
    end
    checks++;
    if (mif.d_ack !== 1'b1 || mif.err !== 1'b1 || mif.d_rdata !== exp_d_rdata) begin
      errors++; $display("FAIL timeout_ack: dack %b err %b rdata %h want 1 1 %h",
                         mif.d_ack, mif.err, mif.d_rdata, exp_d_rdata);
    end
    @(negedge clk);
    checks++;
    if (mif.state !== 2'd0 || mif.err !== 1'b0) begin
      errors++; $display("FAIL timeout_clear: state %0d err %b want 0 0", mif.state, mif.err);
    end
`else
    wait_ack(20, 1000, 1, ok, n_cyc, n_wait, n_rd, n_wr, a, be, w);
    checks++;
    if (ok || mif.state !== 2'd2 || mif.err !== 1'b0) begin
      errors++; $display("FAIL stuck_wait: ack %0d state %0d err %b want 0 2 0",
                         ok, mif.state, mif.err);
    end
    exp_d_rdata = 32'h300 ^ SALT;
    wait_ack(10, 0, 1, ok, n_cyc, n_wait, n_rd, n_wr, a, be, w);
    checks++;
    if (!ok || mif.d_ack !== 1'b1 || mif.err !== 1'b0 || mif.d_rdata !== exp_d_rdata) begin
      errors++; $display("FAIL stuck_release: ack %0d err %b rdata %h want 1 0 %h",
                         ok, mif.err, mif.d_rdata, exp_d_rdata);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_reset_in_wait();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
